// File: rtl/mul.sv
// Sequential radix-2 shift-add multiplier (MULT/MULTU) for HI/LO.
// Optional MUL_EARLY_TERM_EN skips iterations once the multiplier runs out.
module mul #(
  parameter int WIDTH       = 32,
  parameter int COUNT_WIDTH = $clog2(WIDTH + 2)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo,
  output logic             complete
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    FIX,
    DONE
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] W_C   = COUNT_WIDTH'(WIDTH);
  localparam logic [COUNT_WIDTH-1:0] ONE_C = COUNT_WIDTH'(1);

  state_t                 state;
  logic [COUNT_WIDTH-1:0] count;
  logic [WIDTH-1:0]       mcand;
  logic [WIDTH-1:0]       mplr;
  logic [WIDTH-1:0]       acc_hi;
  logic                   negate;

  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] full;
  logic [2*WIDTH-1:0] fixed;

  always_comb begin
    a_abs = multiplicand;
    b_abs = multiplier;
    if (is_signed && multiplicand[WIDTH-1])
      a_abs = -multiplicand;
    if (is_signed && multiplier[WIDTH-1])
      b_abs = -multiplier;
    sum = {1'b0, acc_hi};
    if (mplr[0])
      sum = {1'b0, acc_hi} + {1'b0, mcand};
    full  = {acc_hi, mplr};
    fixed = negate ? -full : full;
  end

`ifdef MUL_EARLY_TERM_EN
  // rem = iterations still to run; the low rem bits of mplr are
  // the multiplier bits not yet consumed.
  logic [COUNT_WIDTH-1:0] rem;
  logic [WIDTH-1:0]       rem_mask;
  logic                   rem_zero;
  logic [2*WIDTH-1:0]     aligned;

  always_comb begin
    rem      = W_C - count + ONE_C;
    rem_mask = {WIDTH{1'b1}} >> (W_C - rem);
    rem_zero = (mplr & rem_mask) == '0;
    aligned  = full >> rem;
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      count      <= '0;
      mcand      <= '0;
      mplr       <= '0;
      acc_hi     <= '0;
      negate     <= 1'b0;
      product_hi <= '0;
      product_lo <= '0;
      complete   <= 1'b0;
    end else if (!en) begin
      state    <= IDLE;
      complete <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          mcand  <= a_abs;
          mplr   <= b_abs;
          negate <= is_signed &
                    (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
          acc_hi <= '0;
          count  <= ONE_C;
          state  <= BUSY;
        end
        BUSY: begin
`ifdef MUL_EARLY_TERM_EN
          if (rem_zero) begin
            {acc_hi, mplr} <= aligned;
            count          <= count + ONE_C;
            state          <= FIX;
          end else begin
            acc_hi <= sum[WIDTH:1];
            mplr   <= {sum[0], mplr[WIDTH-1:1]};
            count  <= count + ONE_C;
            if (count == W_C)
              state <= FIX;
          end
`else
          acc_hi <= sum[WIDTH:1];
          mplr   <= {sum[0], mplr[WIDTH-1:1]};
          count  <= count + ONE_C;
          if (count == W_C)
            state <= FIX;
`endif
        end
        FIX: begin
          {product_hi, product_lo} <= fixed;
          complete <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          complete <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul.sv
// Scoreboard bench for mul: latency, products, hold, abort, reset.
// Latency expectation follows MUL_EARLY_TERM_EN when defined.
module tb_mul;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         en = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] multiplicand = '0;
  logic [W-1:0] multiplier = '0;
  logic [W-1:0] product_hi;
  logic [W-1:0] product_lo;
  logic         complete;

  int errors = 0;
  int checks = 0;
  logic [2*W-1:0] sb[$];
  logic [2*W-1:0] last;

  mul #(.WIDTH(W)) dut (
    .clk(clk),
    .resetn(resetn),
    .en(en),
    .is_signed(is_signed),
    .multiplicand(multiplicand),
    .multiplier(multiplier),
    .product_hi(product_hi),
    .product_lo(product_lo),
    .complete(complete)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [W-1:0] a,
                                        input logic [W-1:0] b,
                                        input logic s);
    logic signed [63:0] sa;
    logic signed [63:0] sbv;
    if (s) begin
      sa  = {{W{a[W-1]}}, a};
      sbv = {{W{b[W-1]}}, b};
      return sa * sbv;
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  function automatic int exp_lat(input logic [W-1:0] b,
                                 input logic s);
`ifdef MUL_EARLY_TERM_EN
    logic [W-1:0] babs;
    int k;
    babs = (s && b[W-1]) ? -b : b;
    k = 0;
    for (int i = 0; i < W; i++)
      if (babs[i]) k = i + 1;
    return (k + 2 < W + 1) ? k + 2 : W + 1;
`else
    return W + 1;
`endif
  endfunction

  task automatic run_op(input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic s,
                        input logic toggle);
    int edge_idx;
    logic done;
    logic [63:0] exp;
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    is_signed    = s;
    en           = 1'b1;
    sb.push_back(model(a, b, s));
    edge_idx = -1;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(posedge clk);
      edge_idx++;
      #1;
      if (complete) done = 1'b1;
      else if (toggle) begin
        multiplicand = $urandom;
        multiplier   = $urandom;
        is_signed    = 1'($urandom);
      end
    end
    check("timeout", 64'(done), 64'd1);
    check("latency", 64'(edge_idx), 64'(exp_lat(b, s)));
    exp = sb.pop_front();
    check("hi", 64'(product_hi), 64'(exp[63:32]));
    check("lo", 64'(product_lo), 64'(exp[31:0]));
    last = exp;
  endtask

  task automatic hold_and_drop(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      check("hold_cmp", 64'(complete), 64'd1);
      check("hold_prod", {product_hi, product_lo}, last);
    end
    @(negedge clk);
    en = 1'b0;
    @(posedge clk);
    #1;
    check("drop_cmp", 64'(complete), 64'd0);
    check("drop_prod", {product_hi, product_lo}, last);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmp", 64'(complete), 64'd0);
    check("rst_prod", {product_hi, product_lo}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    run_op(32'd7, 32'd6, 1'b0, 1'b0);
    check("const_7x6", {product_hi, product_lo}, 64'h2A);
    hold_and_drop(5);

    // abort mid-run: prior product (42) must survive
    @(negedge clk);
    multiplicand = 32'h1234;
    multiplier   = 32'h5678;
    is_signed    = 1'b0;
    en           = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      check("abort_cmp", 64'(complete), 64'd0);
      check("abort_prod", {product_hi, product_lo}, 64'h2A);
    end
    run_op(32'h1234, 32'h5678, 1'b0, 1'b0);
    check("const_restart", {product_hi, product_lo}, 64'h06260060);
    hold_and_drop(1);

    run_op(32'hFFFFFFFD, 32'd5, 1'b1, 1'b0);
    check("const_s", {product_hi, product_lo}, 64'hFFFFFFFF_FFFFFFF1);
    hold_and_drop(1);
    run_op(32'hFFFFFFFD, 32'd5, 1'b0, 1'b0);
    check("const_u", {product_hi, product_lo}, 64'h00000004_FFFFFFF1);
    hold_and_drop(1);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
    check("const_max", {product_hi, product_lo}, 64'hFFFFFFFE_00000001);
    hold_and_drop(1);
    run_op(32'h80000000, 32'h80000000, 1'b1, 1'b0);
    check("const_min", {product_hi, product_lo}, 64'h40000000_00000000);
    hold_and_drop(1);
    run_op(32'h0, 32'h0, 1'b1, 1'b0);
    hold_and_drop(1);
    run_op(32'h9, 32'h1, 1'b0, 1'b0);
    hold_and_drop(1);
    run_op(32'hDEADBEEF, 32'h00012345, 1'b1, 1'b1);
    hold_and_drop(1);
    run_op(32'h7FFFFFFF, 32'h80000001, 1'b1, 1'b1);
    hold_and_drop(1);
    for (int i = 0; i < 6; i++) begin
      run_op($urandom, $urandom >> $urandom_range(0, 31),
             1'($urandom), 1'b1);
      hold_and_drop(1);
    end

    // async reset between edges mid-operation
    @(negedge clk);
    multiplicand = 32'h55;
    multiplier   = 32'hAA;
    en           = 1'b1;
    repeat (5) @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    check("arst_cmp", 64'(complete), 64'd0);
    check("arst_prod", {product_hi, product_lo}, 64'd0);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    resetn = 1'b1;

    run_op(32'd9, 32'd1, 1'b0, 1'b0);
    check("const_9x1", {product_hi, product_lo}, 64'd9);
    hold_and_drop(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul.md
Name: mul

Overview:
- Sequential radix-2 shift-add multiplier for the MIPS32 execute stage; the counterpart to the iterative divider.
- Serves MULT/MULTU and feeds the HI/LO registers.
- Uses the same level-held `en`/`complete` handshake as the divider, so the stall logic treats both units identically.
- One product bit is retired per cycle; sign handling is a final correction step.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH.
- COUNT_WIDTH, $clog2(WIDTH+2), iteration counter width.

Ports:
- clk  input  1  rising-edge clock
- resetn  input  1  asynchronous active-low reset
- en  input  1  held high to request and keep the operation; low aborts or idles
- is_signed  input  1  1 = two's-complement operands (MULT), 0 = unsigned (MULTU); sampled at start
- multiplicand  input  WIDTH  operand A; sampled at start
- multiplier  input  WIDTH  operand B; sampled at start
- product_hi  output  WIDTH  upper half of product (to HI)
- product_lo  output  WIDTH  lower half of product (to LO)
- complete  output  1  product valid; high while in DONE

Behaviour:
- Reset (resetn low, asynchronous):
  - state = IDLE, count = 0, complete = 0.
  - product_hi = 0, product_lo = 0, internal operand/accumulator registers = 0.
- States and transitions:
  - IDLE -> BUSY on the first edge with en = 1 (edge 0).
  - BUSY -> FIX after WIDTH iterations.
  - FIX -> DONE.
  - DONE holds while en = 1.
  - Any state -> IDLE on an edge with en = 0.
- Edge 0 (latch):
  - Store |multiplicand| and |multiplier| as WIDTH-bit unsigned values; |x| applies only when is_signed = 1.
  - negate = is_signed & (msb A ^ msb B).
  - acc_hi = 0, count = 1.
  - Later changes to the operand inputs are ignored.
- BUSY iterations (edges 1..WIDTH):
  - If lsb of the multiplier register = 1: {carry, acc_hi} = acc_hi + mcand (WIDTH+1-bit add).
  - Then shift {carry, acc_hi, mplr} right by 1; mplr is the low half of the accumulator.
  - count increments each edge.
- FIX (edge WIDTH+1):
  - {product_hi, product_lo} = negate ? two's-complement negate of {acc_hi, mplr} : {acc_hi, mplr}.
  - Result is modulo 2^(2*WIDTH).
  - complete = 1 from the following cycle.
- Latency: complete rises after edge WIDTH+1 (33 edges for WIDTH = 32), matching the divider.
- DONE:
  - complete stays 1 and products are stable while en = 1.
  - en = 0 -> IDLE next edge and complete = 0; products are retained.
- Abort (en low mid-operation):
  - IDLE on that edge; complete never asserts.
  - product_hi/lo keep their previous values.
  - A new operation needs at least one cycle of en = 0 before en rises again.
- Signed corner case: |0x80000000| is represented as unsigned 0x80000000, which needs no extra bit.
- Back-to-back: en held high in DONE never restarts. Restart only from IDLE.
- product_hi/lo are written only in FIX.

Optional Feature:
- Macro: MUL_EARLY_TERM_EN.
- Defined:
  - In BUSY, if the remaining multiplier bits are all zero (checked before an iteration), that edge instead aligns the result.
  - Alignment right-shifts {acc_hi, mplr} by the number of remaining iterations, then the block goes to FIX.
  - Let k = bit index of the highest set bit of |multiplier| + 1, with k = 0 for zero.
  - complete rises after edge min(k+2, WIDTH+1). For example, multiplier = 0 gives complete after edge 2.
  - Results are bit-identical to the non-early path.
- Undefined: fixed WIDTH+1 edge latency; no zero detector or alignment shifter is built.

Test Plan:
- Unsigned 7 x 6, en held -> complete rises after edge 33; product_hi = 0x00000000, product_lo = 0x0000002A. Hold en 5 more cycles -> values stable; drop en -> complete = 0 next edge.
- Signed -3 (0xFFFFFFFD) x 5 -> product_hi = 0xFFFFFFFF, product_lo = 0xFFFFFFF1. The same operands unsigned -> hi = 0x00000004, lo = 0xFFFFFFF1.
- Extremes:
  - Unsigned 0xFFFFFFFF x 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001.
  - Signed 0x80000000 x 0x80000000 -> hi = 0x40000000, lo = 0x00000000.
- Abort: en low after edge 10 of 0x1234 x 0x5678 with prior product 42 -> complete stays 0, products remain 0/0x2A. Restarting after one idle cycle yields hi = 0, lo = 0x06260060.
- Operand change after edge 0 (inputs toggled every cycle) -> result reflects only the edge-0 values.
- resetn pulsed low asynchronously mid-operation (between edges) -> complete and products go to 0 immediately. With MUL_EARLY_TERM_EN, 9 x 1 gives complete after edge 3, hi = 0, lo = 9.
